// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl
//   Issue/collect controller for a fixed-latency, never-stalling FMA datapath.
//   Requests are accepted only when a result-buffer slot is already reserved
//   for them (credit = buffer occupancy + ops still in the datapath), so the
//   datapath can run free and every result is guaranteed a landing slot.
//   Results leave in acceptance order through a small circular FIFO.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake; in_op selects FMADD/FMSUB/FNMSUB/FNMADD
//   in_tag, in_a/b/c    : request tag and single-precision operands
//   fma_en              : datapath enable (high whenever not in reset)
//   fma_a/b/c, fma_q    : operands to / result from the a*b+c datapath
//   out_valid/out_ready : result handshake; out_tag/out_result show the FIFO head
//   busy                : any op in the datapath or waiting in the FIFO
//
// fma_issue_ctrl_chk holds the protocol assertions and is instantiated by the top.

module fma_issue_ctrl_chk #(
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 5,
    parameter int CW         = 3,
    parameter int IW         = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count,
    input logic [IW-1:0] inflight
);

    // The buffer must be able to absorb a full datapath plus one entry.
    a_cfg_depth: assert property (@(posedge clk) FIFO_DEPTH >= LAT + 1);

    // The credit rule must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (int'(count) == FIFO_DEPTH)));

    // A pop is only ever issued on a non-empty buffer.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && (int'(count) == 0)));

    // Reserved slots never exceed the buffer size.
    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        (int'(count) + int'(inflight)) <= FIFO_DEPTH);

endmodule

module fma_issue_ctrl #(
    parameter int TAGW       = 8,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [TAGW-1:0] in_tag,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [31:0]     in_c,
    output logic            fma_en,
    output logic [31:0]     fma_a,
    output logic [31:0]     fma_b,
    output logic [31:0]     fma_c,
    input  logic [31:0]     fma_q,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TAGW-1:0] out_tag,
    output logic [31:0]     out_result,
    output logic            busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    // Negate a single-precision value by flipping its sign bit.
    function automatic logic [31:0] flip_sign(input logic [31:0] x);
        return {~x[31], x[30:0]};
    endfunction

    // Advance a FIFO pointer, wrapping at FIFO_DEPTH (need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] nxt;
        if (p == PW'(FIFO_DEPTH - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = p + {{(PW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [SW-1:0]       occupancy_s;
    logic [LAT-1:0]      vld_r;
    logic [TAGW-1:0]     tag_r [LAT];
    logic [IW-1:0]       inflight_r;
    logic [CW-1:0]       count_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [31:0]         res_mem_r [FIFO_DEPTH];
    logic [TAGW-1:0]     tag_mem_r [FIFO_DEPTH];

    // Credit check uses registered occupancy only, so in_ready has no path
    // from in_valid or out_ready.
    assign occupancy_s = SW'(count_r) + SW'(inflight_r);
    assign in_ready    = ~reset & (occupancy_s < SW'(FIFO_DEPTH));
    assign accept_s    = in_valid & in_ready;
    assign push_s      = vld_r[LAT-1];
    assign pop_s       = out_valid & out_ready;

    assign fma_en      = ~reset;
    assign out_valid   = ~reset & (count_r != {CW{1'b0}});
    assign out_result  = res_mem_r[rd_ptr_r];
    assign out_tag     = tag_mem_r[rd_ptr_r];
    assign busy        = ~reset & ((inflight_r != {IW{1'b0}}) | (count_r != {CW{1'b0}}));

    // Operand steering: sign flips implement the subtract/negate variants on
    // an a*b+c datapath; idle cycles present zeros.
    always_comb begin
        fma_a = 32'h0000_0000;
        fma_b = 32'h0000_0000;
        fma_c = 32'h0000_0000;
        if (accept_s) begin
            case (in_op)
                2'b00: begin
                    fma_a = in_a;
                    fma_b = in_b;
                    fma_c = in_c;
                end
                2'b01: begin
                    fma_a = in_a;
                    fma_b = in_b;
                    fma_c = flip_sign(in_c);
                end
                2'b10: begin
                    fma_a = flip_sign(in_a);
                    fma_b = in_b;
                    fma_c = in_c;
                end
                2'b11: begin
                    fma_a = flip_sign(in_a);
                    fma_b = in_b;
                    fma_c = flip_sign(in_c);
                end
                default: begin
                    fma_a = 32'h0000_0000;
                    fma_b = 32'h0000_0000;
                    fma_c = 32'h0000_0000;
                end
            endcase
        end else begin
            fma_a = 32'h0000_0000;
            fma_b = 32'h0000_0000;
            fma_c = 32'h0000_0000;
        end
    end

    // Valid/tag shadow pipeline tracking the datapath; shifts every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                tag_r[i] <= {TAGW{1'b0}};
            end
        end else begin
            vld_r[0] <= accept_s;
            tag_r[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Occupancy counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r <= {IW{1'b0}};
            count_r    <= {CW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
        end else begin
            inflight_r <= inflight_r + IW'(accept_s) - IW'(push_s);
            count_r    <= count_r + CW'(push_s) - CW'(pop_s);
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Result storage; contents are qualified by count_r, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            res_mem_r[wr_ptr_r] <= fma_q;
            tag_mem_r[wr_ptr_r] <= tag_r[LAT-1];
        end
    end

    fma_issue_ctrl_chk #(
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW),
        .IW         (IW)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .pop      (pop_s),
        .count    (count_r),
        .inflight (inflight_r)
    );

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Self-checking bench for fma_issue_ctrl with a 3-cycle behavioural a*b+c
// datapath. Operands are small integers so real arithmetic is exact.

module tb_fma_issue_ctrl;

    localparam int TAGW  = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 5;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_tag;
    logic [31:0] in_a, in_b, in_c;
    logic        fma_en;
    logic [31:0] fma_a, fma_b, fma_c, fma_q;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_tag;
    logic [31:0] out_result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, c;
        logic [7:0]  tag;
        logic [31:0] exp_a, exp_b, exp_c, exp_res;
    } vec_t;

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] res;
    } sb_t;

    vec_t vecs [4];
    sb_t  sb [$];

    fma_issue_ctrl #(.TAGW(TAGW), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .fma_en(fma_en), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_q(fma_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_result(out_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real sp2r(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:23] == 8'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] sp_int(input int v);
        return r2sp(real'(v));
    endfunction

    // Reference result computed from the architectural op definition.
    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        real p;
        real r;
        p = sp2r(a) * sp2r(b);
        case (op)
            2'b00:   r = p + sp2r(c);
            2'b01:   r = p - sp2r(c);
            2'b10:   r = -p + sp2r(c);
            default: r = -p - sp2r(c);
        endcase
        return r2sp(r);
    endfunction

    // Behavioural datapath: a*b+c with LAT=3 cycles of latency, never stalls.
    logic [31:0] dq0, dq1, dq2;
    always @(posedge clk) begin
        dq0 <= r2sp(sp2r(fma_a) * sp2r(fma_b) + sp2r(fma_c));
        dq1 <= dq0;
        dq2 <= dq1;
    end
    assign fma_q = dq2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [7:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_tag   = tag;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int idx;
        int accepted;
        int j;
        int cyc;
        logic [1:0]  rop;
        logic [31:0] ra, rb, rc;
        sb_t item;
        sb_t bp_q [$];

        vecs[0] = '{2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 8'h11,
                    32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000};
        vecs[1] = '{2'b01, 32'h40000000, 32'h40400000, 32'h3F800000, 8'h22,
                    32'h40000000, 32'h40400000, 32'hBF800000, 32'h40A00000};
        vecs[2] = '{2'b10, 32'h40000000, 32'h40400000, 32'h3F800000, 8'h33,
                    32'hC0000000, 32'h40400000, 32'h3F800000, 32'hC0A00000};
        vecs[3] = '{2'b11, 32'h40000000, 32'h40400000, 32'h3F800000, 8'h44,
                    32'hC0000000, 32'h40400000, 32'hBF800000, 32'hC0E00000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_tag = 8'h00; in_a = 32'h0; in_b = 32'h0; in_c = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_fma_en",    32'(fma_en),    32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_fma_en",    32'(fma_en),    32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy",      32'(busy),      32'd0);

        // ---------------- single FMADD latency ----------------
        @(negedge clk);
        drive(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].tag);
        #1;
        check("lat_in_ready", 32'(in_ready), 32'd1);
        check("lat_fma_a", fma_a, vecs[0].exp_a);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("idle_fma_zero", fma_a | fma_b | fma_c, 32'h0);
        check("lat_busy", 32'(busy), 32'd1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("lat_cycles", 32'(lat), 32'd4);
        check("lat_result", out_result, 32'h40E00000);
        check("lat_tag", 32'(out_tag), 32'h11);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("lat_popped_valid", 32'(out_valid), 32'd0);
        check("lat_popped_busy",  32'(busy),      32'd0);

        // ---------------- table: all op encodings back-to-back ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].tag);
            #1;
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            check("tbl_fma_a", fma_a, vecs[i].exp_a);
            check("tbl_fma_b", fma_b, vecs[i].exp_b);
            check("tbl_fma_c", fma_c, vecs[i].exp_c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            #1;
            if (out_valid === 1'b1) begin
                check("tbl_result", out_result, vecs[idx].exp_res);
                check("tbl_tag", 32'(out_tag), 32'(vecs[idx].tag));
                idx++;
            end
            @(negedge clk);
        end
        check("tbl_count", 32'(idx), 32'd4);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(2'b00, sp_int(i + 1), sp_int(2), sp_int(1), 8'h40 + 8'(i));
            #1;
            if (in_ready === 1'b1) begin
                accepted++;
                item.tag = 8'h40 + 8'(i);
                item.res = sp_int(2 * (i + 1) + 1);
                bp_q.push_back(item);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_accepted", 32'(accepted), 32'd5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", out_result, bp_q[0].res);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            check("bp_drain_result", out_result, bp_q[k].res);
            check("bp_drain_tag", 32'(out_tag), 32'(bp_q[k].tag));
            @(negedge clk);
        end
        #1;
        check("bp_empty_valid", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);

        // ---------------- streaming ----------------
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k < 20) drive(2'b00, sp_int((k % 10) + 1), sp_int(3), sp_int(2), 8'(k));
            else in_valid = 1'b0;
            #1;
            if (k < 20) check("st_in_ready", 32'(in_ready), 32'd1);
            j = k - 4;
            if (j >= 0 && j < 20) begin
                check("st_valid", 32'(out_valid), 32'd1);
                check("st_result", out_result, sp_int(3 * ((j % 10) + 1) + 2));
                check("st_tag", 32'(out_tag), 32'(j));
            end else begin
                check("st_idle_valid", 32'(out_valid), 32'd0);
            end
        end

        // ---------------- reset mid-flight ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(2'b00, sp_int(k + 1), sp_int(1), sp_int(1), 8'h80 + 8'(k));
            #1;
            check("mr_in_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_rst_out_valid", 32'(out_valid), 32'd0);
        check("mr_rst_in_ready",  32'(in_ready),  32'd0);
        check("mr_rst_fma_en",    32'(fma_en),    32'd0);
        check("mr_rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mr_first_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check("mr_no_valid", 32'(out_valid), 32'd0);
            check("mr_not_busy", 32'(busy), 32'd0);
            @(negedge clk);
            #1;
        end

        // ---------------- random valid/ready with scoreboard ----------------
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            @(negedge clk);
            rop = 2'($urandom_range(0, 3));
            ra = sp_int(($urandom_range(0, 1) != 0) ? -int'($urandom_range(1, 12)) : int'($urandom_range(1, 12)));
            rb = sp_int(($urandom_range(0, 1) != 0) ? -int'($urandom_range(1, 12)) : int'($urandom_range(1, 12)));
            rc = sp_int(($urandom_range(0, 1) != 0) ? -int'($urandom_range(1, 12)) : int'($urandom_range(1, 12)));
            drive(rop, ra, rb, rc, 8'($urandom_range(0, 255)));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            check("rnd_in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("rnd_spurious_valid", 32'(out_valid), 32'd0);
                end else if (out_ready === 1'b1) begin
                    item = sb.pop_front();
                    check("rnd_result", out_result, item.res);
                    check("rnd_tag", 32'(out_tag), 32'(item.tag));
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                item.tag = in_tag;
                item.res = model_res(rop, ra, rb, rc);
                sb.push_back(item);
                accepted++;
            end
            cyc++;
        end
        check("rnd_accepted", 32'(accepted), 32'd10000);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("drain_spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    item = sb.pop_front();
                    check("drain_result", out_result, item.res);
                    check("drain_tag", 32'(out_tag), 32'(item.tag));
                end
            end
            @(negedge clk);
        end
        #1;
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
